// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/LS memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_LS   = 2'd2
  } resp_owner_e;

  localparam int unsigned ARB_STARVE_MAX = 4;

  function automatic resp_owner_e next_owner(input logic if_rd_gnt, input logic ls_rd_gnt);
    resp_owner_e owner;
    if (if_rd_gnt) begin
      owner = RESP_IF;
    end else if (ls_rd_gnt) begin
      owner = RESP_LS;
    end else begin
      owner = RESP_NONE;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// IF starvation guard: saturating wait counter and force-IF compare.
module mem_port_arbiter_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_if_req,
  input  logic i_if_gnt,
  output logic o_force_if
);

  localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);

  logic [3:0] r_cnt;

  // Counts denied IF cycles, holds at the limit, clears on any IF grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (i_if_gnt) begin
      r_cnt <= 4'd0;
    end else if (i_if_req && (r_cnt < LP_MAX)) begin
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_force_if = (r_cnt == LP_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM read port and one write port between IF and LS requesters.
// Optional macro ARB_PERF_CNT_EN adds stall / dual-grant performance counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [DATA_W-1:0] ls_wmask,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              RamReadEnable,
  output logic [ADDR_W-1:0] RamReadAddr,
  input  logic [DATA_W-1:0] RamReadData,
  output logic              RamWriteEnable,
  output logic [ADDR_W-1:0] RamWriteAddr,
  output logic [DATA_W-1:0] RamWriteData,
  output logic [DATA_W-1:0] RamWriteMask
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_ls_stall,
  output logic [31:0]       perf_conc
`endif
);

  logic        w_force_if;
  logic        w_ls_rd;
  logic        w_ls_wr;
  logic        w_same_dw;
  logic        w_if_gnt;
  logic        w_ls_rd_gnt;
  logic        w_ls_wr_gnt;
  resp_owner_e r_resp_owner;

  assign w_ls_rd   = ls_req & ~ls_we;
  assign w_ls_wr   = ls_req & ls_we;
  assign w_same_dw = (if_addr[ADDR_W-1:3] == ls_addr[ADDR_W-1:3]);

  // Grants are gated by reset so every strobe drops the moment rst asserts.
  // A same-doubleword write holds IF off one cycle so it reads the new data.
  assign w_if_gnt    = rst & if_req & ~(w_ls_wr & w_same_dw) & (~w_ls_rd | w_force_if);
  assign w_ls_rd_gnt = rst & w_ls_rd & ~(if_req & w_force_if);
  assign w_ls_wr_gnt = rst & w_ls_wr;

  assign if_gnt = w_if_gnt;
  assign ls_gnt = w_ls_rd_gnt | w_ls_wr_gnt;

  mem_port_arbiter_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .i_if_req   (if_req),
    .i_if_gnt   (w_if_gnt),
    .o_force_if (w_force_if)
  );

  // RAM read port mux; everything parks at zero when no read is granted.
  always_comb begin
    RamReadEnable = 1'b0;
    RamReadAddr   = {ADDR_W{1'b0}};
    if (w_if_gnt) begin
      RamReadEnable = 1'b1;
      RamReadAddr   = if_addr;
    end else if (w_ls_rd_gnt) begin
      RamReadEnable = 1'b1;
      RamReadAddr   = ls_addr;
    end else begin
      RamReadEnable = 1'b0;
      RamReadAddr   = {ADDR_W{1'b0}};
    end
  end

  // RAM write port, driven only in the LS write grant cycle.
  always_comb begin
    RamWriteEnable = 1'b0;
    RamWriteAddr   = {ADDR_W{1'b0}};
    RamWriteData   = {DATA_W{1'b0}};
    RamWriteMask   = {DATA_W{1'b0}};
    if (w_ls_wr_gnt) begin
      RamWriteEnable = 1'b1;
      RamWriteAddr   = ls_addr;
      RamWriteData   = ls_wdata;
      RamWriteMask   = ls_wmask;
    end else begin
      RamWriteEnable = 1'b0;
      RamWriteAddr   = {ADDR_W{1'b0}};
      RamWriteData   = {DATA_W{1'b0}};
      RamWriteMask   = {DATA_W{1'b0}};
    end
  end

  // Remembers who owns the data RAM returns on the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_owner <= RESP_NONE;
    end else begin
      r_resp_owner <= next_owner(w_if_gnt, w_ls_rd_gnt);
    end
  end

  // Response steering from the registered owner.
  always_comb begin
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_rdata  = {DATA_W{1'b0}};
    ls_rdata  = {DATA_W{1'b0}};
    case (r_resp_owner)
      RESP_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = RamReadData;
      end
      RESP_LS: begin
        ls_rvalid = 1'b1;
        ls_rdata  = RamReadData;
      end
      default: begin
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
      end
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_if_stall;
  logic [31:0] r_perf_ls_stall;
  logic [31:0] r_perf_conc;

  // Free-running stall and dual-grant counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_if_stall <= 32'd0;
      r_perf_ls_stall <= 32'd0;
      r_perf_conc     <= 32'd0;
    end else begin
      if (if_req && !w_if_gnt) begin
        r_perf_if_stall <= r_perf_if_stall + 32'd1;
      end else begin
        r_perf_if_stall <= r_perf_if_stall;
      end
      if (ls_req && !(w_ls_rd_gnt || w_ls_wr_gnt)) begin
        r_perf_ls_stall <= r_perf_ls_stall + 32'd1;
      end else begin
        r_perf_ls_stall <= r_perf_ls_stall;
      end
      if (w_if_gnt && w_ls_wr_gnt) begin
        r_perf_conc <= r_perf_conc + 32'd1;
      end else begin
        r_perf_conc <= r_perf_conc;
      end
    end
  end

  assign perf_if_stall = r_perf_if_stall;
  assign perf_ls_stall = r_perf_ls_stall;
  assign perf_conc     = r_perf_conc;
`endif

endmodule
